lcd_hd44780_resp: RTL and testbench

LCD_HD44780_RESP -- requirements
Module: lcd_hd44780_resp

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_e_sync.sv | 30 +++
 rtl/lcd_hd44780_resp.sv | 162 ++++++++++++++++
 tb/tb_lcd_hd44780_resp.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 responder: opcodes, DDRAM geometry,
// FSM states and address-counter helpers.
package lcd_pkg;

  localparam int AC_W        = 7;
  localparam int DDRAM_DEPTH = 32;
  localparam int IDX_W       = 5;

  localparam logic [AC_W-1:0] LINE0_BASE = 7'h00;
  localparam logic [AC_W-1:0] LINE1_BASE = 7'h40;

  localparam logic [7:0] OP_CLEAR   = 8'h01;
  localparam logic [7:0] OP_HOME    = 8'h02;
  localparam logic [7:0] OP_ENTRY   = 8'h04;
  localparam logic [7:0] OP_DISPLAY = 8'h08;
  localparam logic [7:0] OP_SHIFT   = 8'h10;
  localparam logic [7:0] OP_FUNC    = 8'h20;
  localparam logic [7:0] OP_CGRAM   = 8'h40;
  localparam logic [7:0] OP_DDRAM   = 8'h80;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_CLEAR_FILL
  } lcd_state_t;

  // Only 16 columns per line exist, so stepping jumps between the two lines.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] a, input logic inc);
    if (inc) begin
      if (a == LINE0_BASE + 7'h0F)      return LINE1_BASE;
      else if (a == LINE1_BASE + 7'h0F) return LINE0_BASE;
      else                              return a + 7'd1;
    end else begin
      if (a == LINE0_BASE)              return LINE1_BASE + 7'h0F;
      else if (a == LINE1_BASE)         return LINE0_BASE + 7'h0F;
      else                              return a - 7'd1;
    end
  endfunction

  function automatic logic [IDX_W-1:0] ddram_idx(input logic [AC_W-1:0] a);
    return {a[6], a[3:0]};
  endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// Brings the host enable strobe into the clk domain and flags its edges
// as single-cycle pulses.
module lcd_e_sync (
  input  logic clk,
  input  logic rst,
  input  logic e,
  output logic e_sync,
  output logic e_rise,
  output logic e_fall
);

  logic e_p0, e_p1, e_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_p0 <= 1'b0;
      e_p1 <= 1'b0;
      e_p2 <= 1'b0;
    end else begin
      e_p0 <= e;
      e_p1 <= e_p0;
      e_p2 <= e_p1;
    end
  end

  assign e_sync = e_p1;
  assign e_rise = e_p1 & ~e_p2;
  assign e_fall = ~e_p1 & e_p2;

endmodule

// File: rtl/lcd_hd44780_resp.sv
// HD44780-style bus responder: decodes host instructions, keeps a 2x16
// DDRAM, models the busy flag and serves status/data reads.
module lcd_hd44780_resp #(
  parameter int BUSY_CYC = 40,
  parameter int CLR_CYC  = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rs,
  input  logic       rw,
  input  logic       e,
  input  logic [3:0] db_in,
  output logic [3:0] db_out,
  output logic       db_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       mode4,
  output logic       err,
  input  logic [4:0] mon_addr,
  output logic [7:0] mon_data
);

  import lcd_pkg::*;

  localparam logic [15:0] BUSY_LOAD = 16'(BUSY_CYC - 1);
  localparam logic [15:0] CLR_LOAD  = 16'(CLR_CYC - 1);

  lcd_state_t       state;
  logic [15:0]      cnt;
  logic [IDX_W-1:0] fill_idx;
  logic             id;
  logic             phase;
  logic [3:0]       hi_nib;
  logic [7:0]       rd_word;
  logic [7:0]       ddram [DDRAM_DEPTH];

  logic             e_sync, e_rise, e_fall;
  logic             wr_fall, rd_fall, complete, byte_done, accept, rd_step;
  logic             is_clear, is_clr_home;
  logic [7:0]       wr_byte, live_word, out_word;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [7:0]       mem_wdata;

  lcd_e_sync u_e_sync (
    .clk    (clk),
    .rst    (rst),
    .e      (e),
    .e_sync (e_sync),
    .e_rise (e_rise),
    .e_fall (e_fall)
  );

  assign wr_fall     = e_fall & ~rw;
  assign rd_fall     = e_fall & rw;
  assign complete    = ~mode4 | phase;
  assign byte_done   = wr_fall & complete;
  assign accept      = byte_done & ~busy;
  assign rd_step     = rd_fall & complete & rs;
  assign wr_byte     = mode4 ? {hi_nib, db_in} : {db_in, 4'h0};
  assign is_clear    = ~rs & (wr_byte == OP_CLEAR);
  assign is_clr_home = ~rs & (wr_byte >= OP_CLEAR) & (wr_byte < OP_ENTRY);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ddram_idx(ac);
    mem_wdata = wr_byte;
    if (state == ST_CLEAR_FILL) begin
      mem_we    = 1'b1;
      mem_waddr = fill_idx;
      mem_wdata = BLANK_CHAR;
    end else if (accept && rs) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_BUSY;
      busy     <= 1'b1;
      cnt      <= CLR_LOAD;
      fill_idx <= '0;
      ac       <= LINE0_BASE;
      id       <= 1'b1;
      disp_on  <= 1'b0;
      mode4    <= 1'b0;
      phase    <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (e_fall) phase <= ~phase;
      if (byte_done && busy) err <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            cnt      <= is_clr_home ? CLR_LOAD : BUSY_LOAD;
            fill_idx <= '0;
            state    <= is_clear ? ST_CLEAR_FILL : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == 16'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_CLEAR_FILL: begin
          // The busy count keeps running underneath the fill.
          cnt      <= cnt - 16'd1;
          fill_idx <= fill_idx + 5'd1;
          if (fill_idx == 5'(DDRAM_DEPTH - 1)) state <= ST_BUSY;
        end
        default: state <= ST_BUSY;
      endcase

      if (accept) begin
        if (rs) begin
          ac <= ac_step(ac, id);
        end else if (wr_byte >= OP_DDRAM) begin
          ac <= {wr_byte[6], 2'b00, wr_byte[3:0]};
        end else if (wr_byte >= OP_CGRAM) begin
          // CGRAM is not modelled; only the busy period applies.
        end else if (wr_byte >= OP_FUNC) begin
          mode4 <= ~wr_byte[4];
          phase <= 1'b0;
        end else if (wr_byte >= OP_SHIFT) begin
          // Cursor/display shift has no visible effect here.
        end else if (wr_byte >= OP_DISPLAY) begin
          disp_on <= wr_byte[2];
        end else if (wr_byte >= OP_ENTRY) begin
          id <= wr_byte[1];
        end else if (wr_byte >= OP_HOME) begin
          ac <= LINE0_BASE;
        end else if (wr_byte >= OP_CLEAR) begin
          ac <= LINE0_BASE;
          id <= 1'b1;
        end
      end

      if (rd_step) ac <= ac_step(ac, id);
    end
  end

  // Read word is captured at the start of each strobe so it stays stable
  // even if busy or AC change while the host holds e high.
  always_ff @(posedge clk) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
    if (wr_fall && !complete) hi_nib <= db_in;
    if (e_rise) rd_word <= live_word;
  end

  assign live_word = rs ? ddram[ddram_idx(ac)] : {busy, ac};
  assign out_word  = e_rise ? live_word : rd_word;
  assign db_oe     = e_sync & rw;
  assign db_out    = !db_oe ? 4'h0 : ((mode4 && phase) ? out_word[3:0] : out_word[7:4]);
  assign mon_data  = ddram[mon_addr];

endmodule

// File: tb/tb_lcd_hd44780_resp.sv
// Scoreboard bench for lcd_hd44780_resp: stimulus queues expected state
// snapshots and read nibbles, monitors compare on busy falls and read strobes.
module tb_lcd_hd44780_resp;

  localparam int BUSY = 40;
  localparam int CLR  = 1600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rs = 1'b0, rw = 1'b0, e = 1'b0;
  logic [3:0] db_in = 4'h0;
  logic [4:0] mon_addr = 5'd0;
  logic [3:0] db_out;
  logic       db_oe, busy, disp_on, mode4, err;
  logic [6:0] ac;
  logic [7:0] mon_data;

  lcd_hd44780_resp #(.BUSY_CYC(BUSY), .CLR_CYC(CLR)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .rw       (rw),
    .e        (e),
    .db_in    (db_in),
    .db_out   (db_out),
    .db_oe    (db_oe),
    .busy     (busy),
    .ac       (ac),
    .disp_on  (disp_on),
    .mode4    (mode4),
    .err      (err),
    .mon_addr (mon_addr),
    .mon_data (mon_data)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int         len;
    logic [6:0] ac;
    logic       err;
    logic       mode4;
    logic       disp;
    bit         mon_en;
    logic [4:0] mon_idx;
    logic [7:0] mon_exp;
  } snap_t;

  snap_t      st_q[$];
  logic [3:0] rd_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         if_m4 = 1'b0, x_m4 = 1'b0, x_disp = 1'b0, x_err = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endfunction

  // State snapshots are checked each time busy drops.
  initial begin : monitor
    int    busy_len;
    bit    busy_prev;
    bit    oe_prev;
    int    e_low;
    snap_t s;
    busy_len = 0; busy_prev = 1'b0; oe_prev = 1'b0; e_low = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_len = 0; busy_prev = 1'b0; oe_prev = 1'b0;
      end else begin
        if (db_oe === 1'b1 && !oe_prev) begin
          if (rd_q.size() == 0) check("read_expected", 32'(rd_q.size()), 32'd1);
          else check("db_out", 32'(db_out), 32'(rd_q.pop_front()));
        end
        oe_prev = (db_oe === 1'b1);
        if (e) e_low = 0; else e_low++;
        if (e_low == 4 && rw) check("db_oe_after_e", 32'(db_oe), 32'd0);

        if (busy === 1'b1) begin
          busy_len++;
        end else if (busy_prev) begin
          if (st_q.size() == 0) begin
            check("busy_fall_expected", 32'(st_q.size()), 32'd1);
          end else begin
            s = st_q.pop_front();
            check("busy_len", 32'(busy_len), 32'(s.len));
            check("ac", 32'(ac), 32'(s.ac));
            check("err", 32'(err), 32'(s.err));
            check("mode4", 32'(mode4), 32'(s.mode4));
            check("disp_on", 32'(disp_on), 32'(s.disp));
            if (s.mon_en) begin
              mon_addr = s.mon_idx;
              #1;
              check("mon_data", 32'(mon_data), 32'(s.mon_exp));
            end
          end
          busy_len = 0;
        end
        busy_prev = (busy === 1'b1);
      end
    end
  end

  initial forever begin
    @(negedge rst);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ac", 32'(ac), 32'd0);
    check("rst_disp_on", 32'(disp_on), 32'd0);
    check("rst_mode4", 32'(mode4), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_db_oe", 32'(db_oe), 32'd0);
    check("rst_db_out", 32'(db_out), 32'd0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic push_snap(input int len, input logic [6:0] ac_e, input int midx, input logic [7:0] mexp);
    snap_t s;
    s.len = len; s.ac = ac_e; s.err = x_err; s.mode4 = x_m4; s.disp = x_disp;
    s.mon_en = (midx >= 0); s.mon_idx = 5'(midx); s.mon_exp = mexp;
    st_q.push_back(s);
  endtask

  task automatic strobe(input logic rs_v, input logic rw_v, input logic [3:0] nib);
    @(posedge clk); #1;
    rs = rs_v; rw = rw_v; db_in = nib; e = 1'b1;
    repeat (4) @(posedge clk);
    #1 e = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic write_byte(input logic rs_v, input logic [7:0] b);
    strobe(rs_v, 1'b0, b[7:4]);
    if (if_m4) strobe(rs_v, 1'b0, b[3:0]);
  endtask

  task automatic read_byte(input logic rs_v, input logic [7:0] b);
    rd_q.push_back(b[7:4]);
    rd_q.push_back(b[3:0]);
    strobe(rs_v, 1'b1, 4'h0);
    strobe(rs_v, 1'b1, 4'h0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  task automatic op(input logic rs_v, input logic [7:0] b, input int len,
                    input logic [6:0] ac_e, input int midx, input logic [7:0] mexp);
    push_snap(len, ac_e, midx, mexp);
    write_byte(rs_v, b);
    wait_idle(len + 100);
  endtask

  task automatic init_4bit();
    x_m4 = 1'b0;
    for (int i = 0; i < 3; i++) op(1'b0, 8'h30, BUSY, 7'h00, -1, 8'h00);
    x_m4 = 1'b1;
    op(1'b0, 8'h20, BUSY, 7'h00, -1, 8'h00);
    if_m4 = 1'b1;
  endtask

  initial begin
    #3 rst = 1'b0;
    push_snap(CLR, 7'h00, -1, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle(CLR + 100);
    init_4bit();

    x_disp = 1'b1;
    op(1'b0, 8'h0C, BUSY, 7'h00, -1, 8'h00);
    op(1'b0, 8'h80, BUSY, 7'h00, -1, 8'h00);
    op(1'b1, 8'h41, BUSY, 7'h01, 0, 8'h41);
    op(1'b1, 8'h42, BUSY, 7'h02, 1, 8'h42);

    op(1'b0, 8'h8F, BUSY, 7'h0F, -1, 8'h00);
    op(1'b1, 8'h5A, BUSY, 7'h40, 15, 8'h5A);
    op(1'b0, 8'hCF, BUSY, 7'h4F, -1, 8'h00);
    op(1'b1, 8'h33, BUSY, 7'h00, 31, 8'h33);
    op(1'b0, 8'h04, BUSY, 7'h00, -1, 8'h00);
    op(1'b0, 8'hC0, BUSY, 7'h40, -1, 8'h00);
    op(1'b1, 8'h77, BUSY, 7'h0F, 16, 8'h77);
    op(1'b0, 8'h06, BUSY, 7'h0F, -1, 8'h00);

    // Second data byte lands inside the first one's busy window.
    op(1'b0, 8'h80, BUSY, 7'h00, -1, 8'h00);
    x_err = 1'b1;
    push_snap(BUSY, 7'h01, 1, 8'h42);
    write_byte(1'b1, 8'h55);
    repeat (5) @(posedge clk);
    write_byte(1'b1, 8'h66);
    wait_idle(BUSY + 100);
    op(1'b0, 8'h10, BUSY, 7'h01, 0, 8'h55);

    op(1'b0, 8'hC5, BUSY, 7'h45, -1, 8'h00);
    read_byte(1'b0, 8'h45);
    op(1'b0, 8'h81, BUSY, 7'h01, -1, 8'h00);
    read_byte(1'b1, 8'h42);
    op(1'b0, 8'h10, BUSY, 7'h02, -1, 8'h00);
    op(1'b0, 8'h04, BUSY, 7'h02, -1, 8'h00);
    op(1'b0, 8'h80, BUSY, 7'h00, -1, 8'h00);
    read_byte(1'b1, 8'h55);
    op(1'b0, 8'h10, BUSY, 7'h4F, -1, 8'h00);
    op(1'b0, 8'h06, BUSY, 7'h4F, -1, 8'h00);
    op(1'b0, 8'h85, BUSY, 7'h05, -1, 8'h00);
    op(1'b0, 8'h02, CLR, 7'h00, -1, 8'h00);

    // Clear interrupted by reset: the tail of DDRAM must keep old data.
    x_err = 1'b0; x_m4 = 1'b0; x_disp = 1'b0;
    push_snap(CLR, 7'h00, 31, 8'h33);
    write_byte(1'b0, 8'h01);
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    if_m4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_idle(CLR + 100);

    init_4bit();
    op(1'b0, 8'h01, CLR, 7'h00, 31, 8'h20);
    op(1'b0, 8'h10, BUSY, 7'h00, 0, 8'h20);
    op(1'b0, 8'h10, BUSY, 7'h00, 16, 8'h20);
    op(1'b0, 8'h10, BUSY, 7'h00, 15, 8'h20);

    repeat (10) @(posedge clk);
    check("snap_queue_empty", 32'(st_q.size()), 32'd0);
    check("read_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
